// File: rtl/puf_pkg.sv
// puf_pkg: shared constants for the PUF challenge sequencer slice.
// Holds the FSM state encodings, the challenge width, the LFSR tap mask,
// the default run parameters and the challenge-advance helper.
package puf_pkg;

  localparam int CHALL_W     = 8;
  localparam int DEF_N_BITS  = 8;
  localparam int DEF_TIMEOUT = 1024;

  // Taps at bits 7,5,4,3: x^8+x^6+x^5+x^4+1, maximal length (period 255).
  localparam logic [CHALL_W-1:0] LFSR_TAPS = 8'hB8;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_CLEAR = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  function automatic logic [CHALL_W-1:0] lfsr_next(input logic [CHALL_W-1:0] c);
    return {c[CHALL_W-2:0], ^(c & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/puf_challenge_seq_if.sv
// puf_challenge_seq_if: link between the sequencer and one puf_bit instance.
// master (sequencer): drives puf_chall/puf_en/puf_rst, receives puf_resp/puf_finish.
// slave (puf_bit):    receives puf_chall/puf_en/puf_rst, drives puf_resp/puf_finish.
interface puf_challenge_seq_if import puf_pkg::*; ();

  logic [CHALL_W-1:0] puf_chall;
  logic               puf_en;
  logic               puf_rst;
  logic               puf_resp;
  logic               puf_finish;

  modport master (output puf_chall, puf_en, puf_rst, input puf_resp, puf_finish);
  modport slave  (input puf_chall, puf_en, puf_rst, output puf_resp, puf_finish);

endinterface

// File: rtl/puf_chall_lfsr.sv
// puf_chall_lfsr: challenge register, loads a seed or advances by the LFSR.
// Latency: chall updates on the edge where load or step is sampled.
// Backpressure: none; load has priority over step. Ports: clk, rst, load, step, seed -> chall.
module puf_chall_lfsr import puf_pkg::*; (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [CHALL_W-1:0] seed,
  output logic [CHALL_W-1:0] chall
);

  // An all-zero state would lock the LFSR, so a zero seed becomes 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chall <= '0;
    end else if (load) begin
      chall <= (seed == '0) ? {{(CHALL_W-1){1'b0}}, 1'b1} : seed;
    end else if (step) begin
      chall <= lfsr_next(chall);
    end
  end

endmodule

// File: rtl/puf_challenge_seq.sv
// puf_challenge_seq: runs N_BITS challenges through one puf_bit and packs the responses.
// Latency: per bit 1 CLEAR cycle + k WAIT cycles (k = finish cycle or TIMEOUT); done after 1 + sum.
// Backpressure: start ignored while busy; abort returns to IDLE from any active state, keeping partials.
// Ports: clk, rst, start, abort, seed -> busy, done, err, resp_word; puf (master modport) to puf_bit.
// Build option PUF_MAJORITY_EN: each challenge evaluated three times, bit = majority vote.
module puf_challenge_seq import puf_pkg::*; #(
  parameter int N_BITS  = DEF_N_BITS,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [CHALL_W-1:0]  seed,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [N_BITS-1:0]   resp_word,
  puf_challenge_seq_if.master puf
);

  localparam int IDX_W  = $clog2(N_BITS);
  localparam int TCNT_W = $clog2(TIMEOUT);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [TCNT_W-1:0] tcnt;

  logic accept, tmo, cap, last_idx, last_eval, bit_val;

  assign accept   = (state == ST_IDLE) && start;
  assign tmo      = (tcnt == TCNT_W'(TIMEOUT - 1));
  // A capture ends the current evaluation; abort in the same cycle wins.
  assign cap      = (state == ST_WAIT) && !abort && (puf.puf_finish || tmo);
  assign last_idx = (idx == IDX_W'(N_BITS - 1));

`ifdef PUF_MAJORITY_EN
  logic [1:0] rep;
  logic [1:0] votes;
  logic [1:0] votes_nxt;

  // A timed-out evaluation contributes a 0 vote.
  assign votes_nxt = votes + {1'b0, puf.puf_finish & puf.puf_resp};
  assign last_eval = (rep == 2'd2);
  assign bit_val   = (votes_nxt >= 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep   <= '0;
      votes <= '0;
    end else if (accept) begin
      rep   <= '0;
      votes <= '0;
    end else if (cap) begin
      if (last_eval) begin
        rep   <= '0;
        votes <= '0;
      end else begin
        rep   <= rep + 2'd1;
        votes <= votes_nxt;
      end
    end
  end
`else
  assign last_eval = 1'b1;
  assign bit_val   = puf.puf_finish & puf.puf_resp;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      tcnt      <= '0;
      resp_word <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx       <= '0;
            resp_word <= '0;
            err       <= 1'b0;
            state     <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          tcnt  <= '0;
          state <= abort ? ST_IDLE : ST_WAIT;
        end
        ST_WAIT: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (cap) begin
            if (!puf.puf_finish) err <= 1'b1;
            state <= ST_CLEAR;
            if (last_eval) begin
              resp_word[idx] <= bit_val;
              if (last_idx) state <= ST_DONE;
              else          idx   <= idx + 1'b1;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;  // ST_DONE lasts one cycle
      endcase
    end
  end

  puf_chall_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .step  (cap && last_eval && !last_idx),
    .seed  (seed),
    .chall (puf.puf_chall)
  );

  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE) && !abort;
  assign puf.puf_en  = (state == ST_WAIT);
  assign puf.puf_rst = rst || (state == ST_CLEAR);

endmodule

// File: tb/tb_puf_challenge_seq.sv
module tb_puf_challenge_seq;
  import puf_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] seed = 8'h00;
  logic       busy, done, err;
  logic [7:0] resp_word;

  puf_challenge_seq_if pif ();

  puf_challenge_seq #(.N_BITS(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed),
    .busy(busy), .done(done), .err(err), .resp_word(resp_word), .puf(pif.master)
  );

  always #5 clk = ~clk;

  // PUF model: mode 0 = finish on 3rd WAIT cycle with resp = chall[0];
  // mode 1 = never finishes; mode 2 = scripted per-evaluation results.
  int  mode = 0;
  int  wcnt = 0;
  int  ev = 0;
  int  ev_base = 0;
  int  eidx;
  bit  scr_resp [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  bit  scr_to   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic m_fin, m_rsp;

  always @(posedge clk) begin
    if (pif.puf_rst) wcnt <= 0;
    else if (pif.puf_en) wcnt <= wcnt + 1;
    if (pif.puf_rst && busy) ev <= ev + 1;
  end

  assign eidx = ev - ev_base - 1;

  always_comb begin
    m_fin = 1'b0;
    m_rsp = 1'b0;
    if (mode == 0) begin
      m_fin = pif.puf_en && (wcnt == 2);
      m_rsp = pif.puf_chall[0];
    end else if (mode == 2 && eidx >= 0 && eidx < 6) begin
      m_fin = pif.puf_en && (wcnt == 2) && !scr_to[eidx[2:0]];
      m_rsp = scr_resp[eidx[2:0]];
    end
  end

  assign pif.puf_finish = m_fin;
  assign pif.puf_resp   = m_rsp;

  int n_tests = 0;
  int n_fail = 0;

  // Observations from the last run() call.
  int         n_done, done_cyc, idle_cyc, n_ch;
  logic [7:0] obs_ch [8];

  task automatic do_start(input logic [7:0] s);
    @(negedge clk);
    seed = s;
    start = 1'b1;
    ev_base = ev;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Cycle c is the c-th cycle after the start-sampling edge; sampled at its negedge.
  task automatic run(input int limit, input int start_at, input int abort_at);
    n_done = 0; done_cyc = 0; idle_cyc = 0; n_ch = 0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      start = (c == start_at);
      abort = (c == abort_at);
      if (c == start_at) seed = 8'h33;
      if (done) begin
        n_done++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (!busy && idle_cyc == 0) idle_cyc = c;
      if (pif.puf_rst && busy && n_ch < 8) begin
        obs_ch[n_ch] = pif.puf_chall;
        n_ch++;
      end
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b exp 0", done); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b exp 0", err); end
    n_tests++; if (resp_word !== 8'h00) begin n_fail++; $display("FAIL rst_resp: got %h exp 00", resp_word); end
    n_tests++; if (pif.puf_chall !== 8'h00) begin n_fail++; $display("FAIL rst_chall: got %h exp 00", pif.puf_chall); end
    n_tests++; if (pif.puf_en !== 1'b0) begin n_fail++; $display("FAIL rst_en: got %b exp 0", pif.puf_en); end
    n_tests++; if (pif.puf_rst !== 1'b1) begin n_fail++; $display("FAIL rst_puf_rst: got %b exp 1", pif.puf_rst); end
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++; if (pif.puf_rst !== 1'b0) begin n_fail++; $display("FAIL rst_release: got %b exp 0", pif.puf_rst); end
  endtask

`ifdef PUF_MAJORITY_EN
  task automatic test_majority();
    mode = 2;
    do_start(8'h5A);
    run(42, 0, 39);
    n_tests++; if (resp_word !== 8'h01) begin n_fail++; $display("FAIL maj_resp: got %h exp 01", resp_word); end
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL maj_err: got %b exp 1", err); end
    n_tests++; if (obs_ch[2] !== 8'h5A) begin n_fail++; $display("FAIL maj_chall_hold: got %h exp 5a", obs_ch[2]); end
    n_tests++; if (obs_ch[3] !== 8'hB4) begin n_fail++; $display("FAIL maj_chall_adv: got %h exp b4", obs_ch[3]); end
    n_tests++; if (n_done !== 0) begin n_fail++; $display("FAIL maj_no_done: got %0d exp 0", n_done); end
    mode = 0;
  endtask
`else
  task automatic test_basic();
    mode = 0;
    do_start(8'h5A);
    run(40, 0, 0);
    n_tests++; if (resp_word !== 8'h44) begin n_fail++; $display("FAIL basic_resp: got %h exp 44", resp_word); end
    n_tests++; if (done_cyc !== 33) begin n_fail++; $display("FAIL basic_done_cyc: got %0d exp 33", done_cyc); end
    n_tests++; if (n_done !== 1) begin n_fail++; $display("FAIL basic_done_cnt: got %0d exp 1", n_done); end
    n_tests++; if (idle_cyc !== 34) begin n_fail++; $display("FAIL basic_idle_cyc: got %0d exp 34", idle_cyc); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b exp 0", err); end
    n_tests++; if (obs_ch[0] !== 8'h5A) begin n_fail++; $display("FAIL basic_ch0: got %h exp 5a", obs_ch[0]); end
    n_tests++; if (obs_ch[1] !== 8'hB4) begin n_fail++; $display("FAIL basic_ch1: got %h exp b4", obs_ch[1]); end
    n_tests++; if (obs_ch[2] !== 8'h69) begin n_fail++; $display("FAIL basic_ch2: got %h exp 69", obs_ch[2]); end
    n_tests++; if (obs_ch[7] !== 8'h22) begin n_fail++; $display("FAIL basic_ch7: got %h exp 22", obs_ch[7]); end
  endtask

  task automatic test_timeout();
    mode = 1;
    do_start(8'h5A);
    run(150, 0, 0);
    n_tests++; if (done_cyc !== 137) begin n_fail++; $display("FAIL tmo_done_cyc: got %0d exp 137", done_cyc); end
    n_tests++; if (n_done !== 1) begin n_fail++; $display("FAIL tmo_done_cnt: got %0d exp 1", n_done); end
    n_tests++; if (resp_word !== 8'h00) begin n_fail++; $display("FAIL tmo_resp: got %h exp 00", resp_word); end
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b exp 1", err); end
    mode = 0;
  endtask

  task automatic test_abort();
    mode = 0;
    do_start(8'h5A);
    run(30, 0, 14);
    n_tests++; if (idle_cyc !== 15) begin n_fail++; $display("FAIL abort_idle_cyc: got %0d exp 15", idle_cyc); end
    n_tests++; if (n_done !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d exp 0", n_done); end
    n_tests++; if (resp_word !== 8'h04) begin n_fail++; $display("FAIL abort_partial: got %h exp 04", resp_word); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL abort_err: got %b exp 0", err); end
    n_tests++; if (pif.puf_en !== 1'b0) begin n_fail++; $display("FAIL abort_en: got %b exp 0", pif.puf_en); end
    do_start(8'h5A);
    @(negedge clk);
    n_tests++; if (resp_word !== 8'h00) begin n_fail++; $display("FAIL restart_resp: got %h exp 00", resp_word); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy: got %b exp 1", busy); end
    run(4, 0, 1);
  endtask

  task automatic test_seed_zero();
    mode = 0;
    do_start(8'h00);
    run(40, 0, 0);
    n_tests++; if (obs_ch[0] !== 8'h01) begin n_fail++; $display("FAIL seed0_ch0: got %h exp 01", obs_ch[0]); end
    n_tests++; if (obs_ch[1] !== 8'h02) begin n_fail++; $display("FAIL seed0_ch1: got %h exp 02", obs_ch[1]); end
    n_tests++; if (n_done !== 1) begin n_fail++; $display("FAIL seed0_done_cnt: got %0d exp 1", n_done); end
  endtask

  task automatic test_start_busy();
    mode = 0;
    do_start(8'h5A);
    run(40, 6, 0);
    n_tests++; if (obs_ch[2] !== 8'h69) begin n_fail++; $display("FAIL busy_start_ch2: got %h exp 69", obs_ch[2]); end
    n_tests++; if (resp_word !== 8'h44) begin n_fail++; $display("FAIL busy_start_resp: got %h exp 44", resp_word); end
    n_tests++; if (done_cyc !== 33) begin n_fail++; $display("FAIL busy_start_done_cyc: got %0d exp 33", done_cyc); end
  endtask

  task automatic test_rst_mid();
    mode = 0;
    do_start(8'h5A);
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b exp 0", busy); end
    n_tests++; if (pif.puf_en !== 1'b0) begin n_fail++; $display("FAIL midrst_en: got %b exp 0", pif.puf_en); end
    n_tests++; if (pif.puf_rst !== 1'b1) begin n_fail++; $display("FAIL midrst_puf_rst: got %b exp 1", pif.puf_rst); end
    n_tests++; if (pif.puf_chall !== 8'h00) begin n_fail++; $display("FAIL midrst_chall: got %h exp 00", pif.puf_chall); end
    n_tests++; if (resp_word !== 8'h00) begin n_fail++; $display("FAIL midrst_resp: got %h exp 00", resp_word); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_after: got %b exp 0", busy); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef PUF_MAJORITY_EN
    test_majority();
`else
    test_basic();
    test_timeout();
    test_abort();
    test_seed_zero();
    test_start_busy();
    test_rst_mid();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/puf_challenge_seq.md
Name: puf_challenge_seq

Overview:
Initiator/controller that drives one puf_bit instance. Issues a sequence of 8-bit challenges and, for each one, restarts the PUF, enables it, and waits for its finish strobe. Each returned response bit is packed into an N_BITS-wide response word for the host. Sits between host/control logic and puf_bit: it owns puf_bit's chall/en/rst inputs and consumes its resp/finish outputs.

Parameters:
N_BITS, 8, number of challenges per run = width of resp_word (2..32)
TIMEOUT, 1024, max WAIT cycles per evaluation before giving up (>=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  begin run; sampled only in IDLE
abort  in  1  cancel run from any non-IDLE state
seed  in  8  first challenge of the run; 8'h00 is replaced by 8'h01
busy  out  1  high in every non-IDLE state
done  out  1  one-cycle pulse when resp_word is complete
err  out  1  sticky: at least one evaluation timed out in this run
resp_word  out  N_BITS  collected responses; bit i = response to challenge i
puf_chall  out  8  challenge to puf_bit
puf_en  out  1  enable to puf_bit
puf_rst  out  1  local restart to puf_bit counters/arbiter
puf_resp  in  1  puf_bit response
puf_finish  in  1  puf_bit finish

Behaviour:
- Reset (async): state=IDLE; busy=0, done=0, err=0, resp_word=0, puf_chall=0, puf_en=0, puf_rst=1 while rst high, 0 after.
- States: IDLE, CLEAR, WAIT, DONE.
- IDLE: start=1 → latch puf_chall=seed (0→01), idx=0, resp_word=0, err=0 → CLEAR. start while busy is ignored.
- CLEAR (exactly 1 cycle): puf_rst=1, puf_en=0, timeout counter=0 → WAIT.
- WAIT: puf_en=1, puf_rst=0, tcnt increments each cycle.
  - puf_finish=1 → resp_word[idx]=puf_resp.
  - Else, when tcnt==TIMEOUT-1 → resp_word[idx]=0 and err=1.
  - If finish and timeout coincide, finish wins and err is unchanged.
  - After capture: if idx==N_BITS-1 → DONE. Otherwise idx++, advance puf_chall by LFSR, → CLEAR.
- LFSR: next = {c[6:0], c[7]^c[5]^c[4]^c[3]}. Period 255; never produces 0 from a nonzero seed.
- DONE (1 cycle): done=1, puf_en=0 → IDLE. resp_word and err are held until the next accepted start.
- abort=1 in CLEAR/WAIT/DONE → IDLE on the next edge; puf_en=0, no done pulse, resp_word/err keep their partial values. abort in IDLE has no effect. abort outranks finish in the same cycle (the bit is not captured).
- Timing: finish sampled on WAIT cycle k gives a per-bit cost of 1+k cycles. done rises on cycle 1 + Σ(1+k_i) after the start-sampling edge.
- puf_chall is stable through CLEAR and WAIT of each evaluation.

Optional Feature:
PUF_MAJORITY_EN
- Defined: each challenge is evaluated 3 times (CLEAR+WAIT ×3, same puf_chall). A 2-bit vote counter accumulates puf_resp; a timed-out evaluation votes 0 and sets err. resp_word[idx] = votes>=2. The challenge advances only after the third evaluation.
- Undefined: single evaluation per challenge as above; no vote logic is synthesized.

Decomposition:
- Package puf_pkg: state enum (IDLE/CLEAR/WAIT/DONE), CHALL_W=8, LFSR tap mask constant, default N_BITS/TIMEOUT.
- Sub-module puf_chall_lfsr: 8-bit load/advance register (load, seed, step → chall), with the zero-seed substitution inside it.

Test Plan:
- N_BITS=8, seed=0x5A; PUF model raises finish on the 3rd WAIT cycle with resp=chall[0] → challenges 5A, B4, 69, …; resp_word bits[2:0]=1,0,0 (bit0=0, bit1=0, bit2=1); matches model for all 8 bits; done pulses exactly once on cycle 33; err=0.
- TIMEOUT=16, finish never asserted, N_BITS=8 → each bit takes 17 cycles; resp_word=0; err=1; done on cycle 137.
- seed=0x00 → first puf_chall observed = 0x01; second = 0x02.
- abort in WAIT of bit 3 → IDLE next cycle; puf_en=0; no done; bits 0-2 retained; a new start then clears resp_word and err.
- start pulsed while busy → ignored (idx and challenge sequence unchanged); rst asserted mid-WAIT → all outputs return to reset values immediately (async).
- PUF_MAJORITY_EN: model returns resp pattern 1,0,1 for challenge 0 → resp_word[0]=1; pattern 0,timeout,1 → bit=0 and err=1.
